alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 83 ++++++++
 tb/tb_alu.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: single-cycle registered ALU (ADD/SUB/MUL/DIV/AND/OR/NOR/SLL/SRL/SLT/XOR).
// Result and zero flag are registered; synchronous active-high reset.
// Optional divider: define ALU_DIV_EN to build it. When it is undefined,
// sel=0011 yields zero.
module alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       sel,
   input  logic [WIDTH-1:0] x32bit,
   input  logic [WIDTH-1:0] y32bit,
   input  logic [4:0]       shiftAmount,
   output logic [WIDTH-1:0] res32bit,
   output logic             zf
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_NOR = 4'b0110;
   localparam logic [3:0] OP_SLL = 4'b0111;
   localparam logic [3:0] OP_SRL = 4'b1000;
   localparam logic [3:0] OP_SLT = 4'b1001;
   localparam logic [3:0] OP_XOR = 4'b1010;

   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_result;
   logic [WIDTH-1:0] r_res;
   logic             r_zf;

`ifdef ALU_DIV_EN
   // Unsigned truncating divide; divide-by-zero returns all ones.
   always_comb begin
      w_quot = '1;
      if (y32bit != '0) begin
         w_quot = x32bit / y32bit;
      end
   end
`else
   // Divider not built: the DIV code behaves like an unused code.
   always_comb begin
      w_quot = '0;
   end
`endif

   // Operation select; ADD/SUB/MUL keep only the low WIDTH bits (wrap).
   always_comb begin
      w_result = '0;
      unique case (sel)
         OP_ADD:  w_result = x32bit + y32bit;
         OP_SUB:  w_result = x32bit - y32bit;
         OP_MUL:  w_result = x32bit * y32bit;
         OP_DIV:  w_result = w_quot;
         OP_AND:  w_result = x32bit & y32bit;
         OP_OR:   w_result = x32bit | y32bit;
         OP_NOR:  w_result = ~(x32bit | y32bit);
         OP_SLL:  w_result = y32bit << shiftAmount;
         OP_SRL:  w_result = y32bit >> shiftAmount;
         OP_SLT:  w_result = ($signed(x32bit) < $signed(y32bit)) ? WIDTH'(1) : '0;
         OP_XOR:  w_result = x32bit ^ y32bit;
         default: w_result = '0;
      endcase
   end

   // Register result and zero flag together; reset overrides the sampled op.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_res <= '0;
         r_zf  <= 1'b1;
      end else begin
         r_res <= w_result;
         r_zf  <= (w_result == '0);
      end
   end

   assign res32bit = r_res;
   assign zf       = r_zf;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of alu against an arithmetic model.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [3:0]  sel;
   logic [31:0] x32bit;
   logic [31:0] y32bit;
   logic [4:0]  shiftAmount;
   logic [31:0] res32bit;
   logic        zf;

   int n_vec;
   int n_err;

   alu #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .sel         (sel),
      .x32bit      (x32bit),
      .y32bit      (y32bit),
      .shiftAmount (shiftAmount),
      .res32bit    (res32bit),
      .zf          (zf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on 64-bit quantities.
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sa);
      longint unsigned ua = a;
      longint unsigned ub = b;
      longint unsigned p2 = 64'd1 << sa;
      longint unsigned m  = 64'h1_0000_0000;
      int sa_i = a;
      int sb_i = b;
      case (op)
         4'd0:  return 32'((ua + ub) % m);
         4'd1:  return 32'((ua + m - ub) % m);
         4'd2:  return 32'((ua * ub) % m);
`ifdef ALU_DIV_EN
         4'd3:  return (ub == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
`else
         4'd3:  return 32'd0;
`endif
         4'd4:  return a & b;
         4'd5:  return a | b;
         4'd6:  return ~(a | b);
         4'd7:  return 32'((ub * p2) % m);
         4'd8:  return 32'(ub / p2);
         4'd9:  return (sa_i < sb_i) ? 32'd1 : 32'd0;
         4'd10: return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   // Drive one operation, step one edge, check result and flag.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sa);
      logic [31:0] exp;
      sel = op; x32bit = a; y32bit = b; shiftAmount = sa;
      exp = model(op, a, b, sa);
      @(posedge clk); #1;
      check({tag, "_res"}, res32bit, exp);
      check({tag, "_zf"}, {31'd0, zf}, {31'd0, exp == 32'd0});
   endtask

   initial begin
      logic [31:0] held;
      logic [3:0]  op;
      n_vec = 0; n_err = 0;
      rst = 1'b1; sel = 4'd0; x32bit = 32'd5; y32bit = 32'd7; shiftAmount = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_res", res32bit, 32'd0);
      check("reset_zf", {31'd0, zf}, 32'd1);
      rst = 1'b0;

      run_op("add_ff_1", 4'd0, 32'h0000_00FF, 32'h0000_0001, 5'd0);
      check("add_ff_1_lit", res32bit, 32'h0000_0100);
      run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      check("add_wrap_lit", res32bit, 32'hFFFF_FFFE);
      run_op("sub_wrap", 4'd1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0);
      check("sub_wrap_lit", res32bit, 32'h0000_0002);
      run_op("mul_low", 4'd2, 32'h0000_FFFF, 32'h0000_FFFF, 5'd0);
      check("mul_low_lit", res32bit, 32'hFFFE_0001);
      run_op("div", 4'd3, 32'h0000_FFFF, 32'h0000_00FF, 5'd0);
`ifdef ALU_DIV_EN
      check("div_lit", res32bit, 32'h0000_0101);
`else
      check("div_off_lit", res32bit, 32'h0000_0000);
`endif
      run_op("div_by0", 4'd3, 32'h1234_5678, 32'h0000_0000, 5'd0);
      run_op("nor_ones", 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      check("nor_ones_zf", {31'd0, zf}, 32'd1);
      run_op("xor_same", 4'd10, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 5'd0);
      check("xor_same_zf", {31'd0, zf}, 32'd1);
      run_op("or_ff", 4'd5, 32'h0000_00FF, 32'h0000_0001, 5'd0);
      check("or_ff_lit", res32bit, 32'h0000_00FF);
      run_op("and", 4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
      run_op("sll1", 4'd7, 32'h1111_1111, 32'hFFFF_FFFF, 5'd1);
      check("sll1_lit", res32bit, 32'hFFFF_FFFE);
      run_op("srl1", 4'd8, 32'h1111_1111, 32'hFFFF_FFFF, 5'd1);
      check("srl1_lit", res32bit, 32'h7FFF_FFFF);
      run_op("srl1_one", 4'd8, 32'h0, 32'h0000_0001, 5'd1);
      check("srl1_one_zf", {31'd0, zf}, 32'd1);
      run_op("sll0", 4'd7, 32'hDEAD_BEEF, 32'h8000_0001, 5'd0);
      run_op("srl31", 4'd8, 32'h0, 32'h8000_0000, 5'd31);
      run_op("sll31", 4'd7, 32'h0, 32'h0000_0003, 5'd31);
      run_op("slt_neg", 4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
      check("slt_neg_lit", res32bit, 32'd1);
      run_op("slt_pos", 4'd9, 32'h0000_00FF, 32'h0000_0001, 5'd0);
      check("slt_pos_lit", res32bit, 32'd0);
      run_op("slt_eq", 4'd9, 32'h8000_0000, 32'h8000_0000, 5'd0);
      for (int c = 11; c < 16; c++) begin
         run_op("unused", 4'(c), 32'hFFFF_FFFF, 32'h1234_5678, 5'd3);
      end

      // Outputs must ignore input changes between edges.
      run_op("hold_pre", 4'd0, 32'd10, 32'd20, 5'd0);
      held = res32bit;
      sel = 4'd6; x32bit = 32'd0; y32bit = 32'd0;
      #2;
      check("hold_res", res32bit, held);
      check("hold_zf", {31'd0, zf}, 32'd0);

      // Reset with a valid ADD sampled on the same edge.
      sel = 4'd0; x32bit = 32'd3; y32bit = 32'd4; rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_res", res32bit, 32'd0);
      check("rst_mid_zf", {31'd0, zf}, 32'd1);
      rst = 1'b0;
      run_op("after_rst", 4'd0, 32'd3, 32'd4, 5'd0);

      for (int i = 0; i < 400; i++) begin
         op = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0:       run_op("rand", op, $urandom, $urandom, 5'($urandom));
            1:       run_op("rand_small", op, $urandom_range(0, 8), $urandom_range(0, 8), 5'($urandom));
            2:       run_op("rand_sign", op, $urandom | 32'h8000_0000, $urandom, 5'($urandom));
            default: run_op("rand_eq", op, 32'h5555_AAAA, 32'h5555_AAAA, 5'($urandom));
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
